// File: rtl/imm_gen_pipe_pkg.sv
// Shared format codes and RV opcode constants for the immediate generator.
// decode_opcode resolves a format from the 7-bit opcode for auto-decode builds.
package imm_gen_pipe_pkg;

  localparam logic [2:0] FMT_I    = 3'b000;
  localparam logic [2:0] FMT_S    = 3'b001;
  localparam logic [2:0] FMT_B    = 3'b010;
  localparam logic [2:0] FMT_U    = 3'b011;
  localparam logic [2:0] FMT_J    = 3'b100;
  localparam logic [2:0] FMT_NONE = 3'b101;
  localparam logic [2:0] FMT_ILL  = 3'b111;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;

  function automatic logic [2:0] decode_opcode(input logic [6:0] op, input logic rv64);
    logic [2:0] f;
    case (op)
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_FENCE: f = FMT_I;
      OP_STORE:          f = FMT_S;
      OP_BRANCH:         f = FMT_B;
      OP_LUI, OP_AUIPC:  f = FMT_U;
      OP_JAL:            f = FMT_J;
      OP_OP:             f = FMT_NONE;
      OP_IMM32:          f = rv64 ? FMT_I : FMT_ILL;
      OP_OP32:           f = rv64 ? FMT_NONE : FMT_ILL;
      default:           f = FMT_ILL;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Request/response bundle of the immediate generator.
// master = upstream/downstream environment, slave = the generator itself.
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic [2:0]       imm_sel;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  imm_out;
  logic [2:0]       fmt_out;
  logic [31:0]      instr_out;
  logic [CNT_W-1:0] illegal_cnt;

  modport master (
    output in_valid, instr, imm_sel, out_ready,
    input  in_ready, out_valid, imm_out, fmt_out, instr_out, illegal_cnt
  );

  modport slave (
    input  in_valid, instr, imm_sel, out_ready,
    output in_ready, out_valid, imm_out, fmt_out, instr_out, illegal_cnt
  );
endinterface

// File: rtl/imm_gen_pipe_extract.sv
// Combinational format resolution and immediate extraction.
// Builds a 32-bit sign-correct immediate, then widens it to XLEN from bit 31.
module imm_extract
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit AUTO_DECODE = 1'b0
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      imm_sel,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt
);

  logic        s;
  logic [31:0] imm32;

  assign s = instr[31];

  always_comb begin
    fmt   = FMT_ILL;
    imm32 = '0;
    if (AUTO_DECODE)
      fmt = decode_opcode(instr[6:0], XLEN == 64);
    else if (imm_sel[2:1] == 2'b11)
      fmt = FMT_ILL;
    else
      fmt = imm_sel;

    case (fmt)
      FMT_I:   imm32 = {{20{s}}, instr[31:20]};
      FMT_S:   imm32 = {{20{s}}, instr[31:25], instr[11:7]};
      FMT_B:   imm32 = {{19{s}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm32 = {instr[31:12], 12'b0};
      FMT_J:   imm32 = {{11{s}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase

    imm       = {XLEN{imm32[31]}};
    imm[31:0] = imm32;
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator stage: output register plus one skid entry,
// so in_ready can come from a flop while still sustaining one transfer per cycle.
module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit AUTO_DECODE = 1'b0,
  parameter int CNT_W       = 16
) (
  input  logic         clk,
  input  logic         rst,
  imm_gen_pipe_if.slave bus
);

  logic [XLEN-1:0]  ext_imm;
  logic [2:0]       ext_fmt;
  logic             accept, drain;

  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  out_imm_q, out_imm_d;
  logic [2:0]       out_fmt_q, out_fmt_d;
  logic [31:0]      out_instr_q, out_instr_d;
  logic             skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
  logic [2:0]       skid_fmt_q, skid_fmt_d;
  logic [31:0]      skid_instr_q, skid_instr_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;

  imm_extract #(.XLEN(XLEN), .AUTO_DECODE(AUTO_DECODE)) u_extract (
    .instr   (bus.instr),
    .imm_sel (bus.imm_sel),
    .imm     (ext_imm),
    .fmt     (ext_fmt)
  );

  always_comb begin
    accept        = bus.in_valid & in_ready_q;
    drain         = out_valid_q & bus.out_ready;
    out_valid_d   = out_valid_q;
    out_imm_d     = out_imm_q;
    out_fmt_d     = out_fmt_q;
    out_instr_d   = out_instr_q;
    skid_valid_d  = skid_valid_q;
    skid_imm_d    = skid_imm_q;
    skid_fmt_d    = skid_fmt_q;
    skid_instr_d  = skid_instr_q;
    illegal_cnt_d = illegal_cnt_q;

    if (drain) begin
      out_valid_d  = skid_valid_q;
      skid_valid_d = 1'b0;
      if (skid_valid_q) begin
        out_imm_d   = skid_imm_q;
        out_fmt_d   = skid_fmt_q;
        out_instr_d = skid_instr_q;
      end
    end

    // in_ready is low whenever the skid is full, so an accept never meets a full skid
    if (accept) begin
      if (!out_valid_q || drain) begin
        out_valid_d = 1'b1;
        out_imm_d   = ext_imm;
        out_fmt_d   = ext_fmt;
        out_instr_d = bus.instr;
      end else begin
        skid_valid_d = 1'b1;
        skid_imm_d   = ext_imm;
        skid_fmt_d   = ext_fmt;
        skid_instr_d = bus.instr;
      end
      if (ext_fmt == FMT_ILL && illegal_cnt_q != {CNT_W{1'b1}})
        illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
    end

    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_imm_q     <= '0;
      out_fmt_q     <= FMT_NONE;
      out_instr_q   <= '0;
      skid_valid_q  <= 1'b0;
      skid_imm_q    <= '0;
      skid_fmt_q    <= FMT_NONE;
      skid_instr_q  <= '0;
      in_ready_q    <= 1'b0;
      illegal_cnt_q <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_imm_q     <= out_imm_d;
      out_fmt_q     <= out_fmt_d;
      out_instr_q   <= out_instr_d;
      skid_valid_q  <= skid_valid_d;
      skid_imm_q    <= skid_imm_d;
      skid_fmt_q    <= skid_fmt_d;
      skid_instr_q  <= skid_instr_d;
      in_ready_q    <= in_ready_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.imm_out     = out_imm_q;
  assign bus.fmt_out     = out_fmt_q;
  assign bus.instr_out   = out_instr_q;
  assign bus.illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench: an RV32 explicit-select instance and an RV64 auto-decode
// instance with a narrow counter so saturation is reachable quickly.
module tb_imm_gen_pipe;
  import imm_gen_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32), .CNT_W(16)) if32 ();
  imm_gen_pipe_if #(.XLEN(64), .CNT_W(4))  if64 ();

  imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1'b0), .CNT_W(16)) u_dut32 (
    .clk(clk), .rst(rst), .bus(if32.slave));
  imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(1'b1), .CNT_W(4)) u_dut64 (
    .clk(clk), .rst(rst), .bus(if64.slave));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  // call at a negedge with out_ready=1 and in_ready=1
  task automatic send32(input string tag, input logic [31:0] ins, input logic [2:0] sel,
                        input logic [31:0] eimm, input logic [2:0] efmt);
    if32.in_valid = 1'b1;
    if32.instr    = ins;
    if32.imm_sel  = sel;
    @(negedge clk);
    if32.in_valid = 1'b0;
    chk({tag, "_vld"}, 64'(if32.out_valid), 64'd1);
    chk({tag, "_imm"}, 64'(if32.imm_out), 64'(eimm));
    chk({tag, "_fmt"}, 64'(if32.fmt_out), 64'(efmt));
    chk({tag, "_ins"}, 64'(if32.instr_out), 64'(ins));
  endtask

  task automatic send64(input string tag, input logic [31:0] ins,
                        input logic [63:0] eimm, input logic [2:0] efmt);
    if64.in_valid = 1'b1;
    if64.instr    = ins;
    if64.imm_sel  = 3'b111;
    @(negedge clk);
    if64.in_valid = 1'b0;
    chk({tag, "_vld"}, 64'(if64.out_valid), 64'd1);
    chk({tag, "_imm"}, if64.imm_out, eimm);
    chk({tag, "_fmt"}, 64'(if64.fmt_out), 64'(efmt));
  endtask

  localparam logic [31:0] INS_A = 32'h0010_0093;
  localparam logic [31:0] INS_B = 32'h0020_0093;
  localparam logic [31:0] INS_C = 32'h0030_0093;

  logic [31:0] got[$];
  logic [31:0] exp_q[3];
  logic        take;

  initial begin
    if32.in_valid = 1'b0; if32.instr = '0; if32.imm_sel = '0; if32.out_ready = 1'b1;
    if64.in_valid = 1'b0; if64.instr = '0; if64.imm_sel = '0; if64.out_ready = 1'b1;
    exp_q[0] = INS_A; exp_q[1] = INS_B; exp_q[2] = INS_C;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_vld",  64'(if32.out_valid), 64'd0);
    chk("rst_rdy",  64'(if32.in_ready), 64'd0);
    chk("rst_imm",  64'(if32.imm_out), 64'd0);
    chk("rst_fmt",  64'(if32.fmt_out), 64'(FMT_NONE));
    chk("rst_ins",  64'(if32.instr_out), 64'd0);
    chk("rst_cnt",  64'(if32.illegal_cnt), 64'd0);
    chk("rst_fmt64", 64'(if64.fmt_out), 64'(FMT_NONE));
    rst = 1'b0;
    @(negedge clk);
    chk("rdy_after_rst", 64'(if32.in_ready), 64'd1);
    chk("rdy_after_rst64", 64'(if64.in_ready), 64'd1);

    // RV32, explicit select
    send32("i_neg",  32'hFFF0_0093, 3'b000, 32'hFFFF_FFFF, FMT_I);
    send32("i_pos",  32'h0050_0093, 3'b000, 32'h0000_0005, FMT_I);
    send32("s_neg",  32'hFE20_AE23, 3'b001, 32'hFFFF_FFFC, FMT_S);
    send32("s_pos",  32'h0011_2623, 3'b001, 32'h0000_000C, FMT_S);
    send32("b_neg",  32'hFE00_0CE3, 3'b010, 32'hFFFF_FFF8, FMT_B);
    send32("b_pos",  32'h0020_8463, 3'b010, 32'h0000_0008, FMT_B);
    send32("u_pos",  32'h1234_5037, 3'b011, 32'h1234_5000, FMT_U);
    send32("j_pos",  32'h0080_006F, 3'b100, 32'h0000_0008, FMT_J);
    send32("none",   32'h00B5_0533, 3'b101, 32'h0000_0000, FMT_NONE);
    send32("ill6",   32'hFFF0_0093, 3'b110, 32'h0000_0000, FMT_ILL);
    chk("cnt_after_ill6", 64'(if32.illegal_cnt), 64'd1);
    send32("ill7",   32'hFFFF_FFFF, 3'b111, 32'h0000_0000, FMT_ILL);
    chk("cnt_after_ill7", 64'(if32.illegal_cnt), 64'd2);
    @(negedge clk);
    chk("drained", 64'(if32.out_valid), 64'd0);

    // backpressure: three back-to-back with the consumer stalled
    if32.out_ready = 1'b0;
    if32.in_valid  = 1'b1; if32.imm_sel = 3'b000; if32.instr = INS_A;
    @(negedge clk);
    chk("bp_rdy1", 64'(if32.in_ready), 64'd1);
    chk("bp_out_a", 64'(if32.instr_out), 64'(INS_A));
    if32.instr = INS_B;
    @(negedge clk);
    chk("bp_rdy2", 64'(if32.in_ready), 64'd0);
    chk("bp_hold_a", 64'(if32.instr_out), 64'(INS_A));
    if32.instr = INS_C;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("bp_rdy_low", 64'(if32.in_ready), 64'd0);
      chk("bp_frozen_ins", 64'(if32.instr_out), 64'(INS_A));
      chk("bp_frozen_imm", 64'(if32.imm_out), 64'd1);
      chk("bp_frozen_vld", 64'(if32.out_valid), 64'd1);
    end
    if32.out_ready = 1'b1;
    take = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (if32.out_valid) got.push_back(if32.instr_out);
      take = if32.in_valid & if32.in_ready;
      @(negedge clk);
      if (take) if32.in_valid = 1'b0;
    end
    chk("bp_count", 64'(got.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      chk("bp_order", (i < got.size()) ? 64'(got[i]) : {64{1'bx}}, 64'(exp_q[i]));
    chk("bp_idle", 64'(if32.out_valid), 64'd0);

    // RV64, auto decode (imm_sel driven illegal to show it is ignored)
    send64("u64",    32'h8000_00B7, 64'hFFFF_FFFF_8000_0000, FMT_U);
    send64("j64",    32'hFFDF_F0EF, 64'hFFFF_FFFF_FFFF_FFFC, FMT_J);
    send64("iw64",   32'hFFF0_809B, 64'hFFFF_FFFF_FFFF_FFFF, FMT_I);
    send64("opw64",  32'h40B5_053B, 64'h0, FMT_NONE);
    send64("s64",    32'hFE20_AE23, 64'hFFFF_FFFF_FFFF_FFFC, FMT_S);
    send64("b64",    32'hFE00_0CE3, 64'hFFFF_FFFF_FFFF_FFF8, FMT_B);
    send64("ecall",  32'h0000_0073, 64'h0, FMT_I);
    send64("ill64",  32'h0000_0000, 64'h0, FMT_ILL);
    chk("cnt64_1", 64'(if64.illegal_cnt), 64'd1);

    // stream 15 more illegal requests at full rate, counter must stick at 15
    if64.in_valid = 1'b1; if64.instr = 32'h0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      chk("stream_rdy", 64'(if64.in_ready), 64'd1);
    end
    if64.in_valid = 1'b0;
    chk("cnt64_sat", 64'(if64.illegal_cnt), 64'd15);
    send64("ill64b", 32'h0000_0000, 64'h0, FMT_ILL);
    chk("cnt64_hold", 64'(if64.illegal_cnt), 64'd15);

    // reset with both entries occupied
    if32.out_ready = 1'b0;
    if32.in_valid = 1'b1; if32.instr = INS_A;
    @(negedge clk);
    if32.instr = INS_B;
    @(negedge clk);
    if32.in_valid = 1'b0;
    chk("full_rdy", 64'(if32.in_ready), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_vld", 64'(if32.out_valid), 64'd0);
    chk("mid_rst_cnt", 64'(if32.illegal_cnt), 64'd0);
    chk("mid_rst_rdy", 64'(if32.in_ready), 64'd0);
    chk("mid_rst_cnt64", 64'(if64.illegal_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    if32.out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_rdy", 64'(if32.in_ready), 64'd1);
    for (int k = 0; k < 3; k++) begin
      chk("post_rst_quiet", 64'(if32.out_valid), 64'd0);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
